// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide issue path: M-extension opcodes,
// the idle NOP code and the issue controller state encoding.
package muldiv_pkg;

    // Opcodes understood by the iterative multiply/divide unit.
    localparam logic [7:0] MD_NOP    = 8'h00;
    localparam logic [7:0] OP_MUL    = 8'h01;
    localparam logic [7:0] OP_MULH   = 8'h02;
    localparam logic [7:0] OP_MULHSU = 8'h03;
    localparam logic [7:0] OP_MULHU  = 8'h04;
    localparam logic [7:0] OP_DIV    = 8'h05;
    localparam logic [7:0] OP_DIVU   = 8'h06;
    localparam logic [7:0] OP_REM    = 8'h07;
    localparam logic [7:0] OP_REMU   = 8'h08;

    // Issue controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_issue.sv
// Issue/writeback controller for the iterative multiply/divide unit.
// Holds one request stable at the unit, returns the unit to idle with a NOP,
// and hands the result to writeback.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready_o depends only on state and flush_i; wb_valid_o stays
// high with wb_rd_o/wb_data_o stable until wb_ready_i is seen (or a flush).
module muldiv_issue
    import muldiv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter logic [7:0]  MD_NOP         = muldiv_pkg::MD_NOP
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_inst_i,
    input  logic [31:0] req_rs1_data_i,
    input  logic [31:0] req_rs2_data_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic [7:0]  md_inst_o,
    output logic        md_muldiv_inst_o,
    output logic [31:0] md_reg1_data_o,
    output logic [31:0] md_reg2_data_o,
    input  logic [31:0] md_data_i,
    input  logic        md_ready_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_err_o,
    output logic        busy_o,
    output state_e      dbg_state_o
);

    // Last counter value before a stuck request is abandoned.
    localparam logic [5:0] TO_LAST = 6'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  inst_q, inst_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_err_q, wb_err_d;

    // State and datapath registers; async reset puts the NOP on the unit at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            inst_q    <= MD_NOP;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    // Next-state logic and Moore outputs; flush beats every other event.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        inst_d           = inst_q;
        rs1_d            = rs1_q;
        rs2_d            = rs2_q;
        rd_d             = rd_q;
        wb_data_d        = wb_data_q;
        wb_err_d         = wb_err_q;
        req_ready_o      = 1'b0;
        md_inst_o        = MD_NOP;
        md_muldiv_inst_o = 1'b0;
        md_reg1_data_o   = '0;
        md_reg2_data_o   = '0;
        wb_valid_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = !flush_i;
                // A request targeting x0 is consumed without touching the unit.
                if (req_valid_i && !flush_i && (req_rd_i != 5'd0)) begin
                    inst_d  = req_inst_i;
                    rs1_d   = req_rs1_data_i;
                    rs2_d   = req_rs2_data_i;
                    rd_d    = req_rd_i;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                md_inst_o        = inst_q;
                md_muldiv_inst_o = 1'b1;
                md_reg1_data_o   = rs1_q;
                md_reg2_data_o   = rs2_q;
                cnt_d            = cnt_q + 6'd1;
                if (flush_i) begin
                    state_d = ST_ABORT;
                end else if (md_ready_i) begin
                    wb_data_d = md_data_i;
                    wb_err_d  = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    wb_data_d = '0;
                    wb_err_d  = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                // A flush in this cycle cancels the writeback offer.
                wb_valid_o = !flush_i;
                if (flush_i || wb_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wb_rd_o     = rd_q;
    assign wb_data_o   = wb_data_q;
    assign wb_err_o    = wb_err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue: a latency-programmable unit model computes results
// from the operands the controller presents; expectations come from plain
// M-extension arithmetic on the operands the bench issued.
module tb_muldiv_issue;
  import muldiv_pkg::*;

  localparam int TO = 40;
  localparam logic [7:0] NOP = 8'h00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [7:0] req_inst = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0] req_rd = '0;
  logic flush = 1'b0;
  logic [7:0] md_inst;
  logic md_muldiv;
  logic [31:0] md_reg1, md_reg2;
  logic [31:0] md_data;
  logic md_ready;
  logic wb_valid;
  logic wb_ready = 1'b0;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic wb_err;
  logic busy;
  state_e dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int unit_lat = 34;
  int unit_cnt;

  always #5 clk = ~clk;

  muldiv_issue #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_inst_i(req_inst), .req_rs1_data_i(req_rs1), .req_rs2_data_i(req_rs2),
    .req_rd_i(req_rd), .flush_i(flush),
    .md_inst_o(md_inst), .md_muldiv_inst_o(md_muldiv),
    .md_reg1_data_o(md_reg1), .md_reg2_data_o(md_reg2),
    .md_data_i(md_data), .md_ready_i(md_ready),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_err_o(wb_err),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  // Reference M-extension arithmetic.
  function automatic logic [31:0] mext(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      OP_REMU: begin
        if (b == 0) return a;
        return a % b;
      end
      default: return 32'h0;
    endcase
  endfunction

  // Unit model: answers in the unit_lat-th presented cycle (0 = never).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) unit_cnt <= 0;
    else if (md_muldiv) unit_cnt <= unit_cnt + 1;
    else unit_cnt <= 0;
  end
  assign md_ready = (unit_lat > 0) && md_muldiv && (unit_cnt == unit_lat - 1);
  assign md_data  = md_ready ? mext(md_inst, md_reg1, md_reg2) : 32'hDEAD_BEEF;

  // One request from accept to writeback; starts and ends on a falling edge.
  task automatic run_txn(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input int hold, input logic [31:0] exp_data);
    int busy_n;
    int exp_busy;
    bit exp_err;
    bit ok;
    exp_err  = !(lat >= 1 && lat <= TO);
    exp_busy = exp_err ? TO : lat;
    unit_lat = lat;
    req_inst = op; req_rs1 = a; req_rs2 = b; req_rd = rd; req_valid = 1'b1;
    n_total++;
    if (req_ready !== 1'b1) $display("FAIL accept_ready: got %b want 1", req_ready);
    else n_pass++;
    @(negedge clk);
    req_valid = 1'b0; req_inst = 8'($urandom); req_rs1 = $urandom; req_rs2 = $urandom; req_rd = 5'($urandom);
    busy_n = 0; ok = 1'b1;
    while (wb_valid !== 1'b1 && busy_n < 200) begin
      if (md_inst !== op || md_muldiv !== 1'b1 || md_reg1 !== a || md_reg2 !== b || busy !== 1'b1) ok = 1'b0;
      busy_n++;
      @(negedge clk);
    end
    n_total++;
    if (!ok) $display("FAIL busy_hold: op %h/operands not held at unit (inst=%h)", op, md_inst);
    else n_pass++;
    n_total++;
    if (busy_n != exp_busy) $display("FAIL busy_len: got %0d cycles want %0d", busy_n, exp_busy);
    else n_pass++;
    n_total++;
    if (md_inst !== NOP || md_muldiv !== 1'b0 || md_reg1 !== 32'h0 || md_reg2 !== 32'h0)
      $display("FAIL resp_nop: inst=%h muldiv=%b r1=%h r2=%h want NOP/0", md_inst, md_muldiv, md_reg1, md_reg2);
    else n_pass++;
    n_total++;
    if (wb_valid !== 1'b1 || wb_rd !== rd || wb_data !== exp_data || wb_err !== exp_err)
      $display("FAIL wb_result: v=%b rd=%0d data=%h err=%b want 1/%0d/%h/%b",
               wb_valid, wb_rd, wb_data, wb_err, rd, exp_data, exp_err);
    else n_pass++;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (wb_valid !== 1'b1 || wb_rd !== rd || wb_data !== exp_data || wb_err !== exp_err) ok = 1'b0;
    end
    n_total++;
    if (!ok) $display("FAIL wb_stable: data=%h rd=%0d want %h/%0d over %0d cycles", wb_data, wb_rd, exp_data, rd, hold);
    else n_pass++;
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    n_total++;
    if (busy !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL back_idle: busy=%b wb_valid=%b ready=%b want 0/0/1", busy, wb_valid, req_ready);
    else n_pass++;
  endtask

  // Checks every output against its reset value.
  task automatic check_reset_outputs(input string tag);
    n_total++;
    if (req_ready !== 1'b1 || md_inst !== NOP || md_muldiv !== 1'b0 || md_reg1 !== 32'h0 ||
        md_reg2 !== 32'h0 || wb_valid !== 1'b0 || wb_err !== 1'b0 || wb_data !== 32'h0 ||
        wb_rd !== 5'h0 || busy !== 1'b0)
      $display("FAIL %s: ready=%b inst=%h mi=%b r1=%h r2=%h v=%b err=%b data=%h rd=%0d busy=%b",
               tag, req_ready, md_inst, md_muldiv, md_reg1, md_reg2, wb_valid, wb_err, wb_data, wb_rd, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_values");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_release_idle");
  endtask

  task automatic test_mul();
    run_txn(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 34, 0, 32'hFFFF_FFEB);
  endtask

  task automatic test_divu_hold();
    run_txn(OP_DIVU, 32'd100, 32'd0, 5'd11, 34, 5, 32'hFFFF_FFFF);
  endtask

  task automatic test_flush();
    bit ok;
    unit_lat = 34;
    req_inst = OP_REM; req_rs1 = 32'hFFFF_FFEF; req_rs2 = 32'd5; req_rd = 5'd9; req_valid = 1'b1;
    ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (busy !== 1'b1 || wb_valid !== 1'b0 || md_inst !== OP_REM) ok = 1'b0;
    end
    flush = 1'b1;
    n_total++;
    if (!ok || req_ready !== 1'b0) $display("FAIL flush_busy: ok=%b ready=%b want 1/0", ok, req_ready);
    else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    n_total++;
    if (busy !== 1'b1 || md_inst !== NOP || md_muldiv !== 1'b0 || wb_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL flush_abort: busy=%b inst=%h mi=%b v=%b ready=%b want 1/00/0/0/0",
               busy, md_inst, md_muldiv, wb_valid, req_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || wb_valid !== 1'b0) $display("FAIL flush_idle: busy=%b v=%b want 0/0", busy, wb_valid);
    else n_pass++;
    run_txn(OP_DIV, 32'hFFFF_FFEF, 32'd5, 5'd12, 34, 0, 32'hFFFF_FFFD);
  endtask

  task automatic test_rd0();
    bit ok;
    unit_lat = 34;
    req_inst = OP_MULHU; req_rs1 = 32'h1234_5678; req_rs2 = 32'h9ABC_DEF0; req_rd = 5'd0; req_valid = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (req_ready !== 1'b1 || md_muldiv !== 1'b0 || wb_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
    end
    n_total++;
    if (!ok) $display("FAIL rd0_discard: ready=%b mi=%b v=%b want 1/0/0", req_ready, md_muldiv, wb_valid);
    else n_pass++;
  endtask

  task automatic test_timeout();
    run_txn(OP_DIV, 32'd50, 32'd7, 5'd20, 0, 2, 32'h0);
  endtask

  task automatic test_reset_mid();
    unit_lat = 34;
    req_inst = OP_MUL; req_rs1 = 32'd9; req_rs2 = 32'd9; req_rd = 5'd7; req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_busy: busy=%b want 1", busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(OP_MUL, 32'd3, 32'd4, 5'd3, 34, 0, 32'd12);
  endtask

  task automatic test_random();
    logic [7:0] op;
    logic [31:0] a, b, exp_data;
    logic [4:0] rd;
    int lat;
    for (int n = 0; n < 10; n++) begin
      op = OP_MUL + 8'($urandom_range(0, 7));
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      rd = 5'($urandom_range(1, 31));
      lat = $urandom_range(1, 44);
      exp_data = (lat <= TO) ? mext(op, a, b) : 32'h0;
      run_txn(op, a, b, rd, lat, $urandom_range(0, 3), exp_data);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_divu_hold();
    test_flush();
    test_rd0();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
